// File: rtl/filter_spad_ctrl_if.sv
`default_nettype none
// filter_spad_ctrl_if: control, upstream, spad and MAC signals of filter_spad_ctrl (rev 1.0).
interface filter_spad_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              skip_load;
  logic [ADDR_W-1:0] cfg_len;
  logic [7:0]        cfg_reps;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] spad_addr;
  logic              spad_we;
  logic [DATA_W-1:0] spad_wdata;
  logic [DATA_W-1:0] spad_rdata;
  logic              mac_en;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_zero;
  logic              busy;
  logic              done;

  modport slave (
    input  start, skip_load, cfg_len, cfg_reps, in_valid, in_data, spad_rdata, mac_en,
    output in_ready, spad_addr, spad_we, spad_wdata, w_valid, w_data, w_zero, busy, done
  );

  modport master (
    output start, skip_load, cfg_len, cfg_reps, in_valid, in_data, spad_rdata, mac_en,
    input  in_ready, spad_addr, spad_we, spad_wdata, w_valid, w_data, w_zero, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/filter_spad_ctrl.sv
`default_nettype none
// filter_spad_ctrl: loads filter weights into the PE spad, then streams them to the MAC (rev 1.0).
// Define FSPAD_ZERO_FLAG_EN to drive w_zero for zero weights; otherwise w_zero is tied low.
module filter_spad_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 224
) (
  input  logic                 clk,
  input  logic                 reset,
  filter_spad_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        rep_cnt_q, rep_cnt_d;
  logic [7:0]        reps_q, reps_d;
  logic              in_ready_q, in_ready_d;
  logic              w_valid_q, w_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] cfg_len_clamped;
  logic [7:0]        cfg_reps_eff;
  logic              load_hs;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    cfg_len_clamped = (bus.cfg_len > DEPTH_W) ? DEPTH_W : bus.cfg_len;
    cfg_reps_eff    = (bus.cfg_reps == 8'd0) ? 8'd1 : bus.cfg_reps;
    load_hs         = (state_q == LOAD) && in_ready_q && bus.in_valid;

    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    rep_cnt_d = rep_cnt_q;
    reps_d    = reps_q;
    w_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d  = cfg_len_clamped;
          reps_d = cfg_reps_eff;
          if (cfg_len_clamped == '0) begin
            state_d = DONE;
          end else if (bus.skip_load) begin
            state_d   = STREAM;
            rd_ptr_d  = '0;
            rep_cnt_d = '0;
          end else begin
            state_d  = LOAD;
            wr_ptr_d = '0;
          end
        end
      end
      LOAD: begin
        if (load_hs) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == len_q - 1'b1) begin
            state_d   = STREAM;
            rd_ptr_d  = '0;
            rep_cnt_d = '0;
          end
        end
      end
      STREAM: begin
        // A read issued now is presented to the MAC next cycle (spad reads on the negedge).
        if (bus.mac_en) begin
          w_valid_d = 1'b1;
          if (rd_ptr_q == len_q - 1'b1) begin
            rd_ptr_d  = '0;
            rep_cnt_d = rep_cnt_q + 8'd1;
            if (rep_cnt_q == reps_q - 8'd1) begin
              state_d = DONE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      rep_cnt_q  <= '0;
      reps_q     <= '0;
      in_ready_q <= 1'b0;
      w_valid_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      rep_cnt_q  <= rep_cnt_d;
      reps_q     <= reps_d;
      in_ready_q <= in_ready_d;
      w_valid_q  <= w_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Write strobe follows the live handshake so the spad captures at this cycle's negedge.
  assign wdata          = load_hs ? bus.in_data : '0;
  assign bus.spad_we    = load_hs;
  assign bus.spad_addr  = (state_q == LOAD) ? wr_ptr_q : rd_ptr_q;
  assign bus.spad_wdata = wdata;
  assign bus.in_ready   = in_ready_q;
  assign bus.w_valid    = w_valid_q;
  assign bus.w_data     = bus.spad_rdata;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef FSPAD_ZERO_FLAG_EN
  assign bus.w_zero = w_valid_q && (bus.spad_rdata == '0);
`else
  assign bus.w_zero = 1'b0;
`endif

endmodule
`default_nettype wire
